reward_scheduler: RTL and testbench

- Sequences the reward subsystem: requests a reward from the random generator, holds it on the map for a bounded lifetime, detects pickup by the player tank, and runs one independent duration timer per effect.
- Sits between the reward random generator and the tank, timer and display logic.
- Replaces the shared effect counter with per-effect timers, so overlapping effects expire independently.

---
 rtl/reward_pkg.sv | 32 +++
 rtl/reward_scheduler_if.sv | 17 +
 rtl/reward_effect_timer.sv | 40 ++++
 rtl/reward_scheduler.sv | 163 ++++++++++++++++
 tb/tb_reward_scheduler.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reward_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reward_pkg
// Description : Shared reward types, scheduler state encoding and tick defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package reward_pkg;

    localparam logic [2:0] RWD_NONE       = 3'd0;
    localparam logic [2:0] RWD_INVINCIBLE = 3'd1;
    localparam logic [2:0] RWD_FASTER     = 3'd2;
    localparam logic [2:0] RWD_FROZEN     = 3'd3;
    localparam logic [2:0] RWD_LASER      = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_REQUEST  = 2'd2,
        ST_SHOWN    = 2'd3
    } state_t;

    localparam int c_def_cooldown_ticks = 8;
    localparam int c_def_lifetime_ticks = 40;
    localparam int c_def_effect_ticks   = 20;
    localparam int c_def_timer_w        = 8;

    function automatic logic is_valid_type(input logic [2:0] t);
        return (t >= RWD_INVINCIBLE) && (t <= RWD_LASER);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reward_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : reward_scheduler_if
// Description : Request/candidate handshake between scheduler and generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface reward_scheduler_if;
    logic       gen_req;
    logic       gen_valid;
    logic [2:0] gen_type;
    logic [4:0] gen_xpos;
    logic [4:0] gen_ypos;

    modport master (output gen_req, input gen_valid, gen_type, gen_xpos, gen_ypos);
    modport slave  (input gen_req, output gen_valid, gen_type, gen_xpos, gen_ypos);
endinterface
`default_nettype wire

// File: rtl/reward_effect_timer.sv
`default_nettype none
// ============================================================================
// Module      : reward_effect_timer
// Description : One effect duration counter; active while nonzero.
// Revision    : 1.0 - initial release
// ============================================================================
module reward_effect_timer #(
    parameter int TIMER_W      = 8,
    parameter int EFFECT_TICKS = 20
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_tick,
    input  wire logic i_load,
    input  wire logic i_extend,
    output logic      o_active
);
    localparam logic [TIMER_W:0]   c_max  = {1'b0, {TIMER_W{1'b1}}};
    localparam logic [TIMER_W-1:0] c_load = TIMER_W'(EFFECT_TICKS);

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W:0]   w_sum;

    assign w_sum    = {1'b0, r_count} + {1'b0, c_load};
    assign o_active = (r_count != '0);

    // Load/extend take priority over a coincident tick: no decrement that clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_load;
        end else if (i_extend) begin
            r_count <= (w_sum > c_max) ? {TIMER_W{1'b1}} : w_sum[TIMER_W-1:0];
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/reward_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : reward_scheduler
// Description : Spawns, shows and detects pickup of rewards; per-effect timers.
//               Optional macro REWARD_STACK_EN: re-collect adds to remaining time.
// Revision    : 1.0 - initial release
// ============================================================================
module reward_scheduler import reward_pkg::*; #(
    parameter int COOLDOWN_TICKS = c_def_cooldown_ticks,
    parameter int LIFETIME_TICKS = c_def_lifetime_ticks,
    parameter int EFFECT_TICKS   = c_def_effect_ticks,
    parameter int TIMER_W        = c_def_timer_w
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       tick,
    input  wire logic       enable_reward,
    input  wire logic       enable_game_classic,
    input  wire logic       enable_game_infinity,
    input  wire logic [4:0] mytank_xpos,
    input  wire logic [4:0] mytank_ypos,
    reward_scheduler_if.master gen,
    output logic            spawn_active,
    output logic [2:0]      spawn_type,
    output logic [4:0]      spawn_xpos,
    output logic [4:0]      spawn_ypos,
    output logic            reward_invincible,
    output logic            reward_faster,
    output logic            reward_frozen,
    output logic            reward_laser,
    output logic            reward_addtime
);
    localparam logic [TIMER_W-1:0] c_cool_last = TIMER_W'(COOLDOWN_TICKS - 1);
    localparam logic [TIMER_W-1:0] c_life_last = TIMER_W'(LIFETIME_TICKS - 1);

    state_t             r_state, w_state_nxt;
    logic [TIMER_W-1:0] r_cool_cnt, r_life_cnt;
    logic               r_retry, r_gen_req, r_addtime;
    logic [2:0]         r_type;
    logic [4:0]         r_xpos, r_ypos;
    logic               w_gen_req_nxt, w_accept, w_reject, w_pickup, w_cand_ok;
    logic               w_classic_only, w_infinity_only;
    logic [3:0]         w_start, w_load, w_extend, w_active;

    assign w_cand_ok       = is_valid_type(gen.gen_type) && (gen.gen_xpos != '0) && (gen.gen_ypos != '0);
    assign w_classic_only  = enable_game_classic & ~enable_game_infinity;
    assign w_infinity_only = enable_game_infinity & ~enable_game_classic;

    always_comb begin
        w_state_nxt   = r_state;
        w_gen_req_nxt = 1'b0;
        w_accept      = 1'b0;
        w_reject      = 1'b0;
        w_pickup      = 1'b0;
        if (!enable_reward) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_COOLDOWN;
                ST_COOLDOWN: begin
                    if (tick && (r_cool_cnt == c_cool_last)) begin
                        w_state_nxt   = ST_REQUEST;
                        w_gen_req_nxt = 1'b1;
                    end
                end
                ST_REQUEST: begin
                    if (gen.gen_valid) begin
                        if (w_cand_ok) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_SHOWN;
                        end else begin
                            w_reject = 1'b1;
                        end
                    end else if (r_retry && tick) begin
                        w_gen_req_nxt = 1'b1;
                    end
                end
                ST_SHOWN: begin
                    // Pickup is checked before expiry so a same-clk collision still counts.
                    if ((r_xpos == mytank_xpos) && (r_ypos == mytank_ypos)) begin
                        w_pickup    = 1'b1;
                        w_state_nxt = ST_COOLDOWN;
                    end else if (tick && (r_life_cnt == c_life_last)) begin
                        w_state_nxt = ST_COOLDOWN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cool_cnt <= '0;
            r_life_cnt <= '0;
            r_retry    <= 1'b0;
            r_gen_req  <= 1'b0;
            r_addtime  <= 1'b0;
            r_type     <= RWD_NONE;
            r_xpos     <= '0;
            r_ypos     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gen_req <= w_gen_req_nxt;
            r_addtime <= w_pickup && (r_type == RWD_INVINCIBLE) && w_infinity_only;

            if (r_state != ST_COOLDOWN) r_cool_cnt <= '0;
            else if (tick)              r_cool_cnt <= r_cool_cnt + 1'b1;

            if (r_state != ST_SHOWN) r_life_cnt <= '0;
            else if (tick)           r_life_cnt <= r_life_cnt + 1'b1;

            if (r_state != ST_REQUEST) r_retry <= 1'b0;
            else if (w_reject)         r_retry <= 1'b1;
            else if (w_gen_req_nxt)    r_retry <= 1'b0;

            if (w_accept) begin
                r_type <= gen.gen_type;
                r_xpos <= gen.gen_xpos;
                r_ypos <= gen.gen_ypos;
            end
        end
    end

    assign w_start[0] = w_pickup && (r_type == RWD_INVINCIBLE) && w_classic_only;
    assign w_start[1] = w_pickup && (r_type == RWD_FASTER);
    assign w_start[2] = w_pickup && (r_type == RWD_FROZEN);
    assign w_start[3] = w_pickup && (r_type == RWD_LASER);

    for (genvar i = 0; i < 4; i++) begin : g_timer
`ifdef REWARD_STACK_EN
        assign w_load[i]   = w_start[i] & ~w_active[i];
        assign w_extend[i] = w_start[i] &  w_active[i];
`else
        assign w_load[i]   = w_start[i];
        assign w_extend[i] = 1'b0;
`endif
        reward_effect_timer #(
            .TIMER_W      (TIMER_W),
            .EFFECT_TICKS (EFFECT_TICKS)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (tick),
            .i_load   (w_load[i]),
            .i_extend (w_extend[i]),
            .o_active (w_active[i])
        );
    end

    assign gen.gen_req        = r_gen_req;
    assign spawn_active       = (r_state == ST_SHOWN);
    assign spawn_type         = r_type;
    assign spawn_xpos         = r_xpos;
    assign spawn_ypos         = r_ypos;
    assign reward_invincible  = w_active[0];
    assign reward_faster      = w_active[1];
    assign reward_frozen      = w_active[2];
    assign reward_laser       = w_active[3];
    assign reward_addtime     = r_addtime;
endmodule
`default_nettype wire

// File: tb/tb_reward_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_reward_scheduler
// Description : Self-checking bench for reward_scheduler (scoreboard queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reward_scheduler;
    import reward_pkg::*;

    logic       clk = 1'b0;
    logic       rst, tick, enable_reward, enable_game_classic, enable_game_infinity;
    logic [4:0] mytank_xpos, mytank_ypos;
    logic       spawn_active, reward_invincible, reward_faster, reward_frozen;
    logic       reward_laser, reward_addtime;
    logic [2:0] spawn_type;
    logic [4:0] spawn_xpos, spawn_ypos;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    reward_scheduler_if gen_if ();

    reward_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .tick                 (tick),
        .enable_reward        (enable_reward),
        .enable_game_classic  (enable_game_classic),
        .enable_game_infinity (enable_game_infinity),
        .mytank_xpos          (mytank_xpos),
        .mytank_ypos          (mytank_ypos),
        .gen                  (gen_if),
        .spawn_active         (spawn_active),
        .spawn_type           (spawn_type),
        .spawn_xpos           (spawn_xpos),
        .spawn_ypos           (spawn_ypos),
        .reward_invincible    (reward_invincible),
        .reward_faster        (reward_faster),
        .reward_frozen        (reward_frozen),
        .reward_laser         (reward_laser),
        .reward_addtime       (reward_addtime)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] all_outs();
        return {gen_if.gen_req, spawn_active, spawn_type, spawn_xpos, spawn_ypos,
                reward_invincible, reward_faster, reward_frozen, reward_laser, reward_addtime};
    endfunction

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic restart();
        rst = 1'b1;
        enable_reward = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        enable_reward = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_gen_req(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            do_tick();
            if (gen_if.gen_req) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic offer(input logic [2:0] t, input logic [4:0] x, input logic [4:0] y);
        gen_if.gen_valid = 1'b1;
        gen_if.gen_type  = t;
        gen_if.gen_xpos  = x;
        gen_if.gen_ypos  = y;
        @(negedge clk);
        gen_if.gen_valid = 1'b0;
        gen_if.gen_type  = 3'd0;
        gen_if.gen_xpos  = 5'd0;
        gen_if.gen_ypos  = 5'd0;
    endtask

    task automatic pickup(input logic [4:0] x, input logic [4:0] y);
        mytank_xpos = x;
        mytank_ypos = y;
        @(negedge clk);
        mytank_xpos = 5'd0;
        mytank_ypos = 5'd0;
    endtask

    // which: 0 invincible, 1 faster, 2 frozen, 3 laser, 4 spawn_active
    task automatic ticks_until_low(input int which, output int n);
        logic s;
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            do_tick();
            case (which)
                0:       s = reward_invincible;
                1:       s = reward_faster;
                2:       s = reward_frozen;
                3:       s = reward_laser;
                default: s = spawn_active;
            endcase
            if (!s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (all_outs() !== 20'd0) $display("FAIL reset_outputs: got %h want 0", all_outs());
        else n_pass++;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                do_tick();
                seen |= gen_if.gen_req;
            end
            n_checks++;
            if (seen !== 1'b0) $display("FAIL disabled_no_req: got %b want 0", seen);
            else n_pass++;
        end
    endtask

    task automatic test_spawn_and_frozen();
        int n;
        restart();
        for (int i = 1; i <= 8; i++) begin
            do_tick();
            n_checks++;
            if (gen_if.gen_req !== (i == 8)) $display("FAIL cooldown_req_tick%0d: got %b want %b", i, gen_if.gen_req, (i == 8));
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (gen_if.gen_req !== 1'b0) $display("FAIL req_width: got %b want 0", gen_if.gen_req);
        else n_pass++;

        exp_q.push_back(int'({3'd3, 5'd4, 5'd7}));
        offer(3'd3, 5'd4, 5'd7);
        n_checks++;
        if (spawn_active !== 1'b1) $display("FAIL spawn_active: got %b want 1", spawn_active);
        else n_pass++;
        n = exp_q.pop_front();
        n_checks++;
        if (int'({spawn_type, spawn_xpos, spawn_ypos}) !== n)
            $display("FAIL spawn_latch: got %h want %h", {spawn_type, spawn_xpos, spawn_ypos}, n);
        else n_pass++;

        pickup(5'd4, 5'd7);
        n_checks++;
        if ({reward_frozen, spawn_active} !== 2'b10)
            $display("FAIL frozen_pickup: got frozen=%b spawn=%b want 1/0", reward_frozen, spawn_active);
        else n_pass++;
        exp_q.push_back(20);
        ticks_until_low(2, n);
        n_checks++;
        if (n !== exp_q[0]) $display("FAIL frozen_duration: got %0d want %0d", n, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid();
        int n;
        restart();
        wait_gen_req(n);
        offer(3'd3, 5'd4, 5'd7);
        pickup(5'd4, 5'd7);
        wait_gen_req(n);
        offer(3'd2, 5'd5, 5'd5);
        n_checks++;
        if ({spawn_active, reward_frozen} !== 2'b11)
            $display("FAIL mid_precond: got spawn=%b frozen=%b want 1/1", spawn_active, reward_frozen);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (all_outs() !== 20'd0) $display("FAIL mid_reset_outputs: got %h want 0", all_outs());
        else n_pass++;
        @(negedge clk);
        wait_gen_req(n);
        n_checks++;
        if (n !== 8) $display("FAIL mid_reset_idle_restart: got %0d ticks want 8", n);
        else n_pass++;
    endtask

    task automatic test_addtime();
        int n;
        restart();
        enable_game_infinity = 1'b1;
        enable_game_classic  = 1'b0;
        wait_gen_req(n);
        offer(3'd1, 5'd2, 5'd2);
        pickup(5'd2, 5'd2);
        n_checks++;
        if ({reward_addtime, reward_invincible} !== 2'b10)
            $display("FAIL addtime_pulse: got add=%b inv=%b want 1/0", reward_addtime, reward_invincible);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({reward_addtime, reward_invincible} !== 2'b00)
            $display("FAIL addtime_width: got add=%b inv=%b want 0/0", reward_addtime, reward_invincible);
        else n_pass++;

        enable_game_infinity = 1'b0;
        enable_game_classic  = 1'b1;
        wait_gen_req(n);
        offer(3'd1, 5'd3, 5'd3);
        pickup(5'd3, 5'd3);
        n_checks++;
        if ({reward_addtime, reward_invincible} !== 2'b01)
            $display("FAIL classic_invincible: got add=%b inv=%b want 0/1", reward_addtime, reward_invincible);
        else n_pass++;

        restart();
        enable_game_infinity = 1'b1;
        wait_gen_req(n);
        offer(3'd1, 5'd3, 5'd3);
        pickup(5'd3, 5'd3);
        @(negedge clk);
        n_checks++;
        if ({reward_addtime, reward_invincible} !== 2'b00)
            $display("FAIL both_modes_none: got add=%b inv=%b want 0/0", reward_addtime, reward_invincible);
        else n_pass++;
        enable_game_infinity = 1'b0;
        enable_game_classic  = 1'b0;
    endtask

    task automatic test_lifetime();
        int n;
        restart();
        wait_gen_req(n);
        offer(3'd4, 5'd9, 5'd9);
        exp_q.push_back(40);
        ticks_until_low(4, n);
        n_checks++;
        if (n !== exp_q[0]) $display("FAIL lifetime: got %0d ticks want %0d", n, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        n_checks++;
        if (reward_laser !== 1'b0) $display("FAIL expiry_no_effect: got %b want 0", reward_laser);
        else n_pass++;
        wait_gen_req(n);
        n_checks++;
        if (n !== 8) $display("FAIL cooldown_after_expiry: got %0d want 8", n);
        else n_pass++;

        offer(3'd2, 5'd6, 5'd6);
        repeat (39) do_tick();
        n_checks++;
        if (spawn_active !== 1'b1) $display("FAIL shown_at_39: got %b want 1", spawn_active);
        else n_pass++;
        tick = 1'b1;
        mytank_xpos = 5'd6;
        mytank_ypos = 5'd6;
        @(negedge clk);
        tick = 1'b0;
        mytank_xpos = 5'd0;
        mytank_ypos = 5'd0;
        n_checks++;
        if ({reward_faster, spawn_active} !== 2'b10)
            $display("FAIL pickup_wins_expiry: got faster=%b spawn=%b want 1/0", reward_faster, spawn_active);
        else n_pass++;
    endtask

    task automatic test_stack();
        int n;
        restart();
        wait_gen_req(n);
        offer(3'd4, 5'd8, 5'd8);
        pickup(5'd8, 5'd8);
        wait_gen_req(n);
        repeat (7) do_tick();
        offer(3'd4, 5'd10, 5'd10);
        pickup(5'd10, 5'd10);
`ifdef REWARD_STACK_EN
        exp_q.push_back(25);
`else
        exp_q.push_back(20);
`endif
        ticks_until_low(3, n);
        n_checks++;
        if (n !== exp_q[0]) $display("FAIL laser_recollect: got %0d ticks want %0d", n, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_reject();
        int n;
        restart();
        wait_gen_req(n);
        offer(3'd0, 5'd3, 5'd3);
        n_checks++;
        if ({spawn_active, gen_if.gen_req} !== 2'b00)
            $display("FAIL reject_type0: got spawn=%b req=%b want 0/0", spawn_active, gen_if.gen_req);
        else n_pass++;
        do_tick();
        n_checks++;
        if (gen_if.gen_req !== 1'b1) $display("FAIL repulse_1: got %b want 1", gen_if.gen_req);
        else n_pass++;
        offer(3'd2, 5'd0, 5'd3);
        n_checks++;
        if (spawn_active !== 1'b0) $display("FAIL reject_x0: got %b want 0", spawn_active);
        else n_pass++;
        do_tick();
        n_checks++;
        if (gen_if.gen_req !== 1'b1) $display("FAIL repulse_2: got %b want 1", gen_if.gen_req);
        else n_pass++;
        offer(3'd5, 5'd3, 5'd3);
        do_tick();
        n_checks++;
        if ({spawn_active, gen_if.gen_req} !== 2'b01)
            $display("FAIL reject_type5: got spawn=%b req=%b want 0/1", spawn_active, gen_if.gen_req);
        else n_pass++;
        offer(3'd2, 5'd3, 5'd3);
        n_checks++;
        if (spawn_active !== 1'b1) $display("FAIL accept_after_retry: got %b want 1", spawn_active);
        else n_pass++;
    endtask

    task automatic test_disable();
        int  n;
        logic seen = 1'b0;
        restart();
        wait_gen_req(n);
        offer(3'd4, 5'd5, 5'd6);
        pickup(5'd5, 5'd6);
        wait_gen_req(n);
        offer(3'd3, 5'd7, 5'd7);
        enable_reward = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({spawn_active, reward_laser} !== 2'b01)
            $display("FAIL disable_clear: got spawn=%b laser=%b want 0/1", spawn_active, reward_laser);
        else n_pass++;
        exp_q.push_back(12);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            do_tick();
            seen |= gen_if.gen_req;
            if (!reward_laser) begin
                n = i;
                break;
            end
        end
        n_checks++;
        if (n !== exp_q[0]) $display("FAIL disable_timer_runs: got %0d want %0d", n, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        n_checks++;
        if (seen !== 1'b0) $display("FAIL disable_no_req: got %b want 0", seen);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        enable_reward = 1'b0;
        enable_game_classic = 1'b0;
        enable_game_infinity = 1'b0;
        mytank_xpos = 5'd0;
        mytank_ypos = 5'd0;
        gen_if.gen_valid = 1'b0;
        gen_if.gen_type  = 3'd0;
        gen_if.gen_xpos  = 5'd0;
        gen_if.gen_ypos  = 5'd0;
        @(negedge clk);
        test_reset();
        test_spawn_and_frozen();
        test_reset_mid();
        test_addtime();
        test_lifetime();
        test_stack();
        test_reject();
        test_disable();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire
